// File: rtl/c_reg_piso_v4_0_pkg.sv
// Shared types and constant helpers for the c_reg_piso_v4_0 unload register.
package c_reg_piso_v4_0_pkg;

    // FSM codes: IDLE waits for a word, SHIFT drains one.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } piso_state_e;

    // Longest init string accepted (characters), matches the widest legal word.
    localparam int C_MAX_CHARS = 64;

    // Ceiling log2, at least 1 so a counter always has one bit.
    function automatic int c_clog2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'sd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Turns a right-justified "0101..." literal into a bit vector.
    // Empty or short strings leave the missing upper bits at zero.
    function automatic logic [C_MAX_CHARS-1:0] to_bits(input logic [8*C_MAX_CHARS-1:0] str);
        logic [C_MAX_CHARS-1:0] res;
        res = {C_MAX_CHARS{1'b0}};
        for (int i = 0; i < C_MAX_CHARS; i++) begin
            res[i] = (str[8*i +: 8] == 8'h31);
        end
        return res;
    endfunction

endpackage

// File: rtl/c_reg_piso_v4_0_bitcnt.sv
// Bit-position counter for the PISO register, with a registered last-bit flag.
module c_piso_bitcnt_v4_0
    import c_reg_piso_v4_0_pkg::*;
#(
    parameter int C_WIDTH = 16,
    parameter int CNT_W   = 4
) (
    input  logic i_clk,
    input  logic i_sclr,
    input  logic i_ce,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(C_WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_last;

    // Next count: a clear (new word or word finished) beats an increment.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else if (i_inc) begin
            w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Count register and last flag, frozen while the clock enable is low.
    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_last <= 1'b0;
        end else if (i_ce) begin
            r_cnt  <= w_cnt_nxt;
            r_last <= (w_cnt_nxt == LAST_CNT);
        end else begin
            r_cnt  <= r_cnt;
            r_last <= r_last;
        end
    end

    assign o_last = r_last;

endmodule

// File: rtl/c_reg_piso_v4_0.sv
// Parallel-in / serial-out unload register with valid/ready on both sides.
module c_reg_piso_v4_0
    import c_reg_piso_v4_0_pkg::*;
#(
    parameter int                         C_WIDTH     = 16,
    parameter int                         C_SHIFT_DIR = 0,
    parameter int                         C_HAS_CE    = 0,
    parameter logic [8*C_MAX_CHARS-1:0]   C_SINIT_VAL = "",
    parameter int                         C_IDLE_VAL  = 0
) (
    input  logic               i_clk,
    input  logic               i_sclr,
    input  logic               i_ce,
    input  logic [C_WIDTH-1:0] i_d,
    input  logic               i_load_valid,
    output logic               o_load_ready,
    output logic               o_sdout,
    output logic               o_svalid,
    input  logic               i_sready,
    output logic               o_slast,
    output logic               o_busy
);

    localparam int                     CNT_W      = c_clog2(C_WIDTH);
    localparam logic [C_MAX_CHARS-1:0] SINIT_FULL = to_bits(C_SINIT_VAL);
    localparam logic [C_WIDTH-1:0]     SINIT      = SINIT_FULL[C_WIDTH-1:0];
    localparam logic                   IDLE_BIT   = (C_IDLE_VAL != 0);
    localparam logic                   LSB_FIRST  = (C_SHIFT_DIR != 0);

    piso_state_e        r_state;
    piso_state_e        w_state_nxt;
    logic [C_WIDTH-1:0] r_shreg;
    logic [C_WIDTH-1:0] w_shreg_nxt;
    logic               r_sdout;
    logic               r_svalid;
    logic               r_busy;
    logic               w_ce;
    logic               w_load_ready;
    logic               w_load;
    logic               w_beat;
    logic               w_last;
    logic               w_cnt_clr;
    logic               w_out_bit;

    assign w_ce   = (C_HAS_CE != 0) ? i_ce : 1'b1;
    assign w_load = i_load_valid & w_load_ready;
    assign w_beat = r_svalid & i_sready & w_ce;
    // Restart the count on a new word, and also when the last bit leaves so it never wraps.
    assign w_cnt_clr = w_load | (w_beat & w_last);

    // Load acceptance: any time in IDLE, in SHIFT only while the final bit is being taken.
    always_comb begin
        w_load_ready = 1'b0;
        if (i_sclr || !w_ce) begin
            w_load_ready = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE:  w_load_ready = 1'b1;
                ST_SHIFT: w_load_ready = w_last & i_sready;
                default:  w_load_ready = 1'b0;
            endcase
        end
    end

    // Next state and shift register contents.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_shreg_nxt = i_d;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_load) begin
                    w_shreg_nxt = i_d;
                    w_state_nxt = ST_SHIFT;
                end else if (w_beat) begin
                    w_shreg_nxt = LSB_FIRST ? {1'b0, r_shreg[C_WIDTH-1:1]}
                                            : {r_shreg[C_WIDTH-2:0], 1'b0};
                    w_state_nxt = w_last ? ST_IDLE : ST_SHIFT;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output bit as it will appear once the next state is registered.
    assign w_out_bit = (w_state_nxt == ST_SHIFT)
                     ? (LSB_FIRST ? w_shreg_nxt[0] : w_shreg_nxt[C_WIDTH-1])
                     : IDLE_BIT;

    // State, shift register and registered serial-side outputs.
    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            r_state  <= ST_IDLE;
            r_shreg  <= SINIT;
            r_sdout  <= IDLE_BIT;
            r_svalid <= 1'b0;
            r_busy   <= 1'b0;
        end else if (w_ce) begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_sdout  <= w_out_bit;
            r_svalid <= (w_state_nxt == ST_SHIFT);
            r_busy   <= (w_state_nxt == ST_SHIFT);
        end else begin
            r_state  <= r_state;
            r_shreg  <= r_shreg;
            r_sdout  <= r_sdout;
            r_svalid <= r_svalid;
            r_busy   <= r_busy;
        end
    end

    c_piso_bitcnt_v4_0 #(
        .C_WIDTH (C_WIDTH),
        .CNT_W   (CNT_W)
    ) u_bitcnt (
        .i_clk  (i_clk),
        .i_sclr (i_sclr),
        .i_ce   (w_ce),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_beat),
        .o_last (w_last)
    );

    assign o_load_ready = w_load_ready;
    assign o_sdout      = r_sdout;
    assign o_svalid     = r_svalid;
    assign o_slast      = w_last;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_c_reg_piso_v4_0.sv
// Directed bench for c_reg_piso_v4_0: unit 0 is MSB-first with CE and an init
// string, unit 1 is LSB-first without CE and idles high.
module tb_c_reg_piso_v4_0;

    logic       clk;
    logic [1:0] sclr, ce, lv, sready;
    logic [1:0] lr, sd, sv, sl, bz;
    logic [7:0] d [2];

    int n_chk;
    int n_fail;

    c_reg_piso_v4_0 #(
        .C_WIDTH(8), .C_SHIFT_DIR(0), .C_HAS_CE(1),
        .C_SINIT_VAL("10101010"), .C_IDLE_VAL(0)
    ) dut0 (
        .i_clk(clk), .i_sclr(sclr[0]), .i_ce(ce[0]), .i_d(d[0]),
        .i_load_valid(lv[0]), .o_load_ready(lr[0]), .o_sdout(sd[0]),
        .o_svalid(sv[0]), .i_sready(sready[0]), .o_slast(sl[0]), .o_busy(bz[0])
    );

    c_reg_piso_v4_0 #(
        .C_WIDTH(8), .C_SHIFT_DIR(1), .C_HAS_CE(0),
        .C_SINIT_VAL(""), .C_IDLE_VAL(1)
    ) dut1 (
        .i_clk(clk), .i_sclr(sclr[1]), .i_ce(ce[1]), .i_d(d[1]),
        .i_load_valid(lv[1]), .o_load_ready(lr[1]), .o_sdout(sd[1]),
        .o_svalid(sv[1]), .i_sready(sready[1]), .o_slast(sl[1]), .o_busy(bz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Loads one word into unit u and checks every serial bit; rnd throttles SREADY.
    task automatic run_word(input int u, input logic [7:0] w, input bit lsb, input bit rnd);
        logic exp_bit;
        logic idle_bit;
        int   guard;
        idle_bit = (u == 1);
        @(negedge clk);
        d[u] = w; lv[u] = 1'b1; sready[u] = 1'b1;
        #1 chk("idle_load_ready", {7'd0, lr[u]}, 8'd1);
        @(negedge clk);
        lv[u] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_bit = lsb ? w[i] : w[7-i];
            chk("svalid", {7'd0, sv[u]}, 8'd1);
            chk("sdout", {7'd0, sd[u]}, {7'd0, exp_bit});
            chk("slast", {7'd0, sl[u]}, {7'd0, (i == 7)});
            if (rnd) begin
                guard = 0;
                sready[u] = 1'($urandom_range(0, 1));
                while (sready[u] == 1'b0) begin
                    @(negedge clk);
                    chk("hold_sdout", {7'd0, sd[u]}, {7'd0, exp_bit});
                    chk("hold_slast", {7'd0, sl[u]}, {7'd0, (i == 7)});
                    guard++;
                    sready[u] = (guard > 20) ? 1'b1 : 1'($urandom_range(0, 1));
                end
            end else begin
                sready[u] = 1'b1;
            end
            @(negedge clk);
        end
        chk("end_svalid", {7'd0, sv[u]}, 8'd0);
        chk("end_busy", {7'd0, bz[u]}, 8'd0);
        chk("end_sdout", {7'd0, sd[u]}, {7'd0, idle_bit});
    endtask

    initial begin
        logic [7:0] w;
        logic       exp_bit;
        n_chk = 0; n_fail = 0;
        sclr = 2'b11; ce = 2'b11; lv = 2'b00; sready = 2'b11;
        d[0] = 8'h00; d[1] = 8'h00;

        // Reset state of both units while SCLR is held.
        repeat (2) @(negedge clk);
        chk("rst_load_ready0", {7'd0, lr[0]}, 8'd0);
        chk("rst_svalid0", {7'd0, sv[0]}, 8'd0);
        chk("rst_busy0", {7'd0, bz[0]}, 8'd0);
        chk("rst_slast0", {7'd0, sl[0]}, 8'd0);
        chk("rst_sdout0", {7'd0, sd[0]}, 8'd0);
        chk("rst_sdout1", {7'd0, sd[1]}, 8'd1);
        chk("rst_shreg0", dut0.r_shreg, 8'hAA);
        sclr = 2'b00;
        #1 chk("post_rst_ready0", {7'd0, lr[0]}, 8'd1);

        // 1: MSB-first A5.
        run_word(0, 8'hA5, 1'b0, 1'b0);
        // 2: LSB-first A5 and 01, idle level high.
        run_word(1, 8'hA5, 1'b1, 1'b0);
        run_word(1, 8'h01, 1'b1, 1'b0);

        // 3: back-to-back FF then 00 with LOAD_VALID held.
        @(negedge clk);
        d[0] = 8'hFF; lv[0] = 1'b1; sready[0] = 1'b1;
        #1 chk("b2b_ready_idle", {7'd0, lr[0]}, 8'd1);
        @(negedge clk);
        d[0] = 8'h00;
        for (int i = 0; i < 16; i++) begin
            exp_bit = (i < 8) ? 1'b1 : 1'b0;
            if (i == 8) lv[0] = 1'b0;
            #1;
            chk("b2b_svalid", {7'd0, sv[0]}, 8'd1);
            chk("b2b_sdout", {7'd0, sd[0]}, {7'd0, exp_bit});
            chk("b2b_slast", {7'd0, sl[0]}, {7'd0, (i % 8 == 7)});
            chk("b2b_ready", {7'd0, lr[0]}, {7'd0, (i % 8 == 7)});
            @(negedge clk);
        end
        chk("b2b_end_svalid", {7'd0, sv[0]}, 8'd0);

        // 4: random SREADY throttling, same stream as test 1.
        run_word(0, 8'hA5, 1'b0, 1'b1);

        // 5: SCLR after three bits of C3.
        @(negedge clk);
        d[0] = 8'hC3; lv[0] = 1'b1; sready[0] = 1'b1;
        @(negedge clk);
        lv[0] = 1'b0;
        w = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            chk("sclr_pre_sdout", {7'd0, sd[0]}, {7'd0, w[7-i]});
            chk("sclr_pre_slast", {7'd0, sl[0]}, 8'd0);
            @(negedge clk);
        end
        sclr[0] = 1'b1;
        #1 chk("sclr_ready", {7'd0, lr[0]}, 8'd0);
        @(negedge clk);
        chk("sclr_svalid", {7'd0, sv[0]}, 8'd0);
        chk("sclr_busy", {7'd0, bz[0]}, 8'd0);
        chk("sclr_sdout", {7'd0, sd[0]}, 8'd0);
        chk("sclr_slast", {7'd0, sl[0]}, 8'd0);
        chk("sclr_shreg", dut0.r_shreg, 8'hAA);
        sclr[0] = 1'b0;
        run_word(0, 8'h3C, 1'b0, 1'b0);

        // 6: CE low for four cycles after two bits of 96.
        @(negedge clk);
        d[0] = 8'h96; lv[0] = 1'b1; sready[0] = 1'b1;
        @(negedge clk);
        lv[0] = 1'b0;
        w = 8'h96;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                ce[0] = 1'b0;
                d[0] = 8'hFF; lv[0] = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    #1;
                    chk("ce_ready", {7'd0, lr[0]}, 8'd0);
                    chk("ce_sdout", {7'd0, sd[0]}, {7'd0, w[5]});
                    chk("ce_svalid", {7'd0, sv[0]}, 8'd1);
                    chk("ce_cnt", {5'd0, dut0.u_bitcnt.r_cnt}, 8'd2);
                    @(negedge clk);
                end
                ce[0] = 1'b1; lv[0] = 1'b0;
            end
            chk("ce_stream_sdout", {7'd0, sd[0]}, {7'd0, w[7-i]});
            chk("ce_stream_slast", {7'd0, sl[0]}, {7'd0, (i == 7)});
            @(negedge clk);
        end
        chk("ce_end_svalid", {7'd0, sv[0]}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
